// File: rtl/booth_radix4_seq_ctrl.sv
// booth_radix4_seq_ctrl
//   Iterative radix-4 Booth multiplier. One Booth digit is retired per clock:
//   the low three bits of a right-shifting copy of the multiplier form the
//   triple {B[2i+1],B[2i],B[2i-1]}, and the matching partial product is taken
//   from a left-shifting copy of the sign-extended multiplicand and added into
//   a 2*WIDTH accumulator.
//
//   Handshake semantics (both sides): a transfer happens on a rising edge
//   where valid and ready are both high. The producer holds op_a/op_b and
//   in_valid until in_ready is seen. The product stays on product/out_valid
//   until out_ready is seen.
//
//   Optional feature: define BOOTH_EARLY_TERM_EN to finish as soon as every
//   remaining Booth digit is known to be zero.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  operand handshake (in_ready high only in IDLE)
//   op_a, op_b          signed multiplicand / multiplier
//   out_valid,out_ready product handshake (out_valid high only in DONE)
//   product             signed op_a*op_b, 2*WIDTH bits
//   busy                high while digits are being retired
//   cycles              BUSY cycles used by the last operation
module booth_radix4_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic [CNT_W:0]       cycles
);

  localparam int PW = 2 * WIDTH;
  localparam int HALF = WIDTH / 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W:0]   CYC_ONE  = (CNT_W + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // b_sh holds {B, B[-1]}; bit WIDTH is the multiplier sign bit.
  logic [WIDTH:0]   b_sh;
  logic [WIDTH:0]   b_next;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mag;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    acc_sum;
  logic [CNT_W-1:0] count;
  logic [2:0]       trip;
  logic             x_one;
  logic             x_two;
  logic             comp;
  logic             last;

  assign trip  = b_sh[2:0];
  assign x_one = trip[1] ^ trip[0];
  assign x_two = (trip == 3'b011) | (trip == 3'b100);
  assign comp  = trip[2] & ~(trip[1] & trip[0]);

  // mcand already carries the 2i weighting, so no variable shifter is needed.
  assign mag     = x_one ? mcand : (x_two ? (mcand << 1) : '0);
  assign pp      = comp ? (~mag + PW'(1)) : mag;
  assign acc_sum = acc + pp;

  // Arithmetic shift by one digit; the sign fill keeps the remaining-bits
  // test below valid all the way to the top of the multiplier.
  assign b_next = {{2{b_sh[WIDTH]}}, b_sh[WIDTH:2]};

`ifdef BOOTH_EARLY_TERM_EN
  // Remaining bits all equal means every later digit decodes to zero.
  assign last = (count == LAST_CNT) || (b_next == '0) || (b_next == '1);
`else
  assign last = (count == LAST_CNT);
`endif

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state == S_BUSY);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_BUSY;
      S_BUSY:  if (last)      state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_sh    <= '0;
      mcand   <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
      cycles  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mcand <= {{WIDTH{op_a[WIDTH-1]}}, op_a};
            b_sh  <= {op_b, 1'b0};
            acc   <= '0;
            count <= '0;
          end
        end
        S_BUSY: begin
          acc   <= acc_sum;
          mcand <= mcand << 2;
          b_sh  <= b_next;
          count <= count + CNT_ONE;
          if (last) begin
            product <= acc_sum;
            cycles  <= {1'b0, count} + CYC_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix4_seq_ctrl.sv
// Bench for booth_radix4_seq_ctrl: directed corner operations with literal
// expected products, backpressure and mid-operation reset, then randomized
// operand pairs checked against a plain signed-multiply reference.
module tb_booth_radix4_seq_ctrl;

  localparam int W    = 16;
  localparam int CW   = 4;
  localparam int HALF = W / 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [W-1:0]    op_a = '0;
  logic [W-1:0]    op_b = '0;
  logic            in_ready;
  logic            out_valid;
  logic            busy;
  logic [2*W-1:0]  product;
  logic [CW:0]     cycles;

  int checks = 0;
  int failures = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
  int busy_run = 0;
  logic prev_ov = 1'b0;

  logic [2*W-1:0] exp_q[$];
  logic [CW:0]    expc_q[$];

  booth_radix4_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy), .cycles(cycles)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] model_product(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] r;
    r = $signed(a) * $signed(b);
    return r;
  endfunction

  function automatic logic [CW:0] model_cycles(input logic [W-1:0] b);
`ifdef BOOTH_EARLY_TERM_EN
    logic signed [W-1:0] s;
    for (int k = 1; k <= HALF; k++) begin
      s = $signed(b) >>> (2 * k - 1);
      if (s == 0 || s == -1) return (CW + 1)'(k);
    end
`endif
    return (CW + 1)'(HALF);
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'hFFFF;
      3: return 16'h7FFF;
      4: return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-1:0] exp, input logic [CW:0] expc);
    bit ok;
    ok = 1'b0;
    exp_q.push_back(exp);
    expc_q.push_back(expc);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout actual=no_in_ready required=in_ready");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a = W'($urandom);
    op_b = W'($urandom);
  endtask

  task automatic drain();
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
      expc_q.delete();
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_run = 0;
        prev_ov = 1'b0;
      end else begin
        check("in_ready_only_idle", in_ready, !busy && !out_valid);
        if (busy) busy_run++;
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_out_valid actual=1 required=0");
          end else begin
            check("product", product, exp_q[0]);
            check("cycles", cycles, expc_q[0]);
            if (!prev_ov) check("busy_cycles", busy_run, expc_q[0]);
            if (out_ready) begin
              void'(exp_q.pop_front());
              void'(expc_q.pop_front());
              busy_run = 0;
            end
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    int e;
    e = 0;
`ifdef BOOTH_EARLY_TERM_EN
    e = 1;
`endif
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_product", product, 32'h0);
    check("rst_cycles", cycles, 5'd0);
    rst_n = 1'b1;

    // Directed corners, literal expectations.
    send(16'h8000, 16'h8000, 32'h4000_0000, 5'd8);
    send(16'h1234, 16'hFFFF, 32'hFFFF_EDCC, e ? 5'd1 : 5'd8);
    send(16'h0003, 16'h0005, 32'h0000_000F, e ? 5'd2 : 5'd8);
    send(16'h8000, 16'h0001, 32'hFFFF_8000, e ? 5'd1 : 5'd8);
    send(16'hFFFF, 16'hFFFF, 32'h0000_0001, e ? 5'd1 : 5'd8);
    drain();

    // Backpressure: product held 5 cycles while the next op waits.
    rdy_mode = 2;
    send(16'h7FFF, 16'h7FFF, 32'h3FFF_0001, 5'd8);
    fork
      send(16'h0002, 16'hFFFD, 32'hFFFF_FFFA, e ? 5'd2 : 5'd8);
      begin
        seen = 1'b0;
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          if (out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        check("bp_out_valid_seen", seen, 1'b1);
        repeat (5) begin
          @(negedge clk);
          check("bp_hold_valid", out_valid, 1'b1);
          check("bp_in_ready_low", in_ready, 1'b0);
        end
        rdy_mode = 0;
      end
    join
    drain();

    // Reset three cycles into an operation.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    op_a = 16'h1234;
    op_b = 16'h5678;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_product", product, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1'b1);
    check("post_reset_busy", busy, 1'b0);
    send(16'hFFF0, 16'h0010, 32'hFFFF_FF00, e ? 5'd3 : 5'd8);
    drain();

    // Randomized pairs against the reference.
    rdy_mode = 1;
    for (int n = 0; n < 2000; n++) begin
      logic [W-1:0] a, b;
      a = pick();
      b = pick();
      send(a, b, model_product(a, b), model_cycles(b));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
